mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single memory/IO bus (256x16 synchronous RAM at 0x000–0x0FF, switch input at 0x140, LED register at 0x100) between the CPU (port 0) and a second bus master (port 1, e.g. a DMA or debug loader). It selects one request at a time with round-robin priority and drives the shared `mem_cmd`/`mem_addr`/write-data bus from registers. It captures read data after the RAM's one-cycle read latency and returns it to the granted port with a valid pulse.

## Interface
- `ADDR_W`, 9, bus address width (bit 8 selects IO space)
- `DATA_W`, 16, data width
- `clk` in 1: single clock; all state updates on posedge
- `reset` in 1: synchronous, active-high
- `req_cmd0`, `req_cmd1` in 3: one-hot command; `MNONE`=001, `MREAD`=010, `MWRITE`=100
- `req_addr0`, `req_addr1` in ADDR_W: request address
- `req_wdata0`, `req_wdata1` in DATA_W: write data
- `grant0`, `grant1` out 1: one-cycle pulse; request accepted
- `rvalid0`, `rvalid1` out 1: one-cycle pulse; `rdata*` updated
- `rdata0`, `rdata1` out DATA_W: last read result per port, held
- `bus_cmd` out 3: shared bus command (registered)
- `bus_addr` out ADDR_W: shared bus address (registered)
- `bus_wdata` out DATA_W: shared bus write data (registered)
- `bus_rdata` in DATA_W: RAM `dout` / IO read mux
- `cmd_err` out 1: sticky flag; a non-one-hot, non-`MNONE` command was seen

## Operation
- **States:** `S_IDLE`, `S_ISSUE`, `S_RDATA`.
- **`S_IDLE`:**
  - A port is requesting when its `req_cmd` is `MREAD` or `MWRITE`.
  - If none is requesting, stay in `S_IDLE` with `bus_cmd` = `MNONE`.
  - Otherwise, at the clock edge, pick the winner and latch its cmd, addr and wdata into the `bus_*` registers.
  - Assert `grant<winner>` for the next cycle, then go to `S_ISSUE`.
- **Round-robin:**
  - A `last` pointer records the last granted port.
  - When both ports request, the port ≠ `last` wins.
  - When one port requests, it wins. `last` updates on every grant.
- **`S_ISSUE`:**
  - The bus presents the command for exactly this cycle.
  - For `MWRITE`: the RAM or LED register writes at the end of this cycle. Next state is `S_IDLE` with `bus_cmd` = `MNONE`.
  - For `MREAD`: next state is `S_RDATA`, and `bus_cmd`/`bus_addr` are held.
- **`S_RDATA`:**
  - `bus_cmd` stays `MREAD`, so the IO read decode remains active.
  - At the end of this cycle, `bus_rdata` is captured into `rdata<winner>`. `rvalid<winner>` is pulsed during the following cycle, and the state returns to `S_IDLE`.
- **Request inputs:**
  - Requests are sampled only in `S_IDLE`; in other states they are ignored.
  - A requester holds its request until it sees its grant.
  - It may change its inputs in the cycle its grant is high, because the arbiter has already sampled them.
- **Invalid commands:**
  - Any command other than 001, 010 or 100 is treated as no request.
  - It sets `cmd_err`, which stays set until `reset`.
- **`rdata` holding:** `rdata0`/`rdata1` keep their value until the next completed read for that port.

## Timing
- **Reset values** (applied at the first clock edge with `reset` high, from any state):
  - State `S_IDLE`; `bus_cmd` = `MNONE`; `bus_addr` = 0; `bus_wdata` = 0.
  - Grants 0; rvalids 0; `rdata0`/`rdata1` = 0; `cmd_err` = 0.
  - `last` = 1, so port 0 wins the first tie.
- **Reset mid-operation:** any in-flight read is dropped and no `rvalid` pulses. A write in `S_ISSUE` during a reset cycle is still presented to the bus in that cycle. The RAM may commit it.
- **Write, request first sampled in cycle t (`S_IDLE`):**
  - t+1: `bus_cmd` = `MWRITE` and `grant` = 1.
  - t+2: `S_IDLE`.
  - Maximum throughput is one write per 2 cycles.
- **Read, request first sampled in cycle t:**
  - t+1: `grant` = 1, `bus_cmd` = `MREAD`.
  - t+2: `S_RDATA`.
  - t+3: `rvalid` = 1 and `rdata` valid; the state is `S_IDLE`, so a new request can be sampled in t+3.
  - Total: 3 cycles per read.
- **Pulse exclusivity:** at most one `grant*` and at most one `rvalid*` high in any cycle.
- **Unused address bits:** `bus_addr[8]` and the upper bits are passed through unchanged; the arbiter does no address decoding.

## Structure
- The `MNONE`/`MREAD`/`MWRITE` encodings and the state encodings go in a shared definitions file included by the CPU, the top level and this block.
- One small combinational sub-module, `rr_pick2`, takes `req0`, `req1` and `last` and returns `valid` and `winner`. Everything else stays in `mem_arbiter`.

## Test plan
- **Reset:** hold `reset` 2 cycles, then release with no requests → `bus_cmd` = 001, grants and rvalids 0, `cmd_err` 0 for 5 cycles.
- **Port 0 write:** port 0 writes 0x100 / 0x00A5 → exactly one cycle of `bus_cmd` = 100, `bus_addr` = 0x100, `bus_wdata` = 0x00A5, with `grant0` high in the same cycle.
- **Port 1 read:** preload mem[0x05] = 0x1234; port 1 reads 0x005 at cycle t → `grant1` at t+1, `rvalid1` at t+3 with `rdata1` = 0x1234; `rdata0` unchanged.
- **Contention:** both ports continuously request reads after reset → grant order 0, 1, 0, 1; the rvalid of each port follows its grant by 2 cycles.
- **Invalid command:** port 0 presents 3'b011 → no grant, `bus_cmd` stays 001, `cmd_err` = 1 until the next `reset`.
- **Reset during read:** assert `reset` during `S_RDATA` of a read to 0x140 with SW = 0x3C → no `rvalid`, `rdata` = 0, and `bus_cmd` = 001 the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory/IO bus arbiter: bus command
// encodings, FSM state encoding and small command-classification helpers.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 9;
    localparam int ARB_DATA_W = 16;
    localparam int CMD_W      = 3;

    localparam logic [CMD_W-1:0] MNONE  = 3'b001;
    localparam logic [CMD_W-1:0] MREAD  = 3'b010;
    localparam logic [CMD_W-1:0] MWRITE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    // A port is asking for the bus only with a read or a write.
    function automatic logic cmd_is_req(input logic [CMD_W-1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

    // Anything outside the three one-hot encodings is malformed.
    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
        return (cmd == MNONE) || cmd_is_req(cmd);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and shared-bus signals of the arbiter. The slave modport
// is the arbiter's view; master is the requesters plus the memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ARB_ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::ARB_DATA_W
);
    logic [2:0]        req_cmd0;
    logic [2:0]        req_cmd1;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic              grant0;
    logic              grant1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [2:0]        bus_cmd;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              cmd_err;

    modport slave (
        input  req_cmd0, req_cmd1, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  bus_rdata,
        output grant0, grant1, rvalid0, rvalid1, rdata0, rdata1,
        output bus_cmd, bus_addr, bus_wdata, cmd_err
    );

    modport master (
        output req_cmd0, req_cmd1, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output bus_rdata,
        input  grant0, grant1, rvalid0, rvalid1, rdata0, rdata1,
        input  bus_cmd, bus_addr, bus_wdata, cmd_err
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Winner is 1 when port 1 alone requests, or on a tie when port 0 went last.
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory/IO bus between two masters. A granted command is held on
// registered bus outputs; reads are captured after the RAM's one-cycle latency
// and returned to the owning port with a single-cycle rvalid pulse.
//
// state   | meaning
// S_IDLE  | bus idle (MNONE); sample requests and pick a winner
// S_ISSUE | granted command on the bus; writes commit at end of cycle
// S_RDATA | read held on the bus while RAM dout / IO mux settles; capture
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave arb
);

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   req0;
    logic   req1;
    logic   bad_cmd;
    logic   pick_valid;
    logic   pick_winner;

    // Classify the incoming commands; malformed ones never count as requests.
    always_comb begin
        req0    = cmd_is_req(arb.req_cmd0);
        req1    = cmd_is_req(arb.req_cmd1);
        bad_cmd = ~cmd_is_legal(arb.req_cmd0) | ~cmd_is_legal(arb.req_cmd1);
    end

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the command on the bus decides whether ISSUE goes on to RDATA.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (arb.bus_cmd == MREAD) ? S_RDATA : S_IDLE;
            S_RDATA: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered bus, grant/rvalid pulses, read capture and the round-robin pointer.
    // The pointer also names the owner of the transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            arb.bus_cmd   <= MNONE;
            arb.bus_addr  <= '0;
            arb.bus_wdata <= '0;
            arb.grant0    <= 1'b0;
            arb.grant1    <= 1'b0;
            arb.rvalid0   <= 1'b0;
            arb.rvalid1   <= 1'b0;
            arb.rdata0    <= '0;
            arb.rdata1    <= '0;
            arb.cmd_err   <= 1'b0;
            last          <= 1'b1;
        end else begin
            arb.grant0  <= 1'b0;
            arb.grant1  <= 1'b0;
            arb.rvalid0 <= 1'b0;
            arb.rvalid1 <= 1'b0;
            if (bad_cmd) begin
                arb.cmd_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        last <= pick_winner;
                        if (pick_winner) begin
                            arb.grant1    <= 1'b1;
                            arb.bus_cmd   <= arb.req_cmd1;
                            arb.bus_addr  <= arb.req_addr1;
                            arb.bus_wdata <= arb.req_wdata1;
                        end else begin
                            arb.grant0    <= 1'b1;
                            arb.bus_cmd   <= arb.req_cmd0;
                            arb.bus_addr  <= arb.req_addr0;
                            arb.bus_wdata <= arb.req_wdata0;
                        end
                    end else begin
                        arb.bus_cmd <= MNONE;
                    end
                end
                S_ISSUE: begin
                    if (arb.bus_cmd != MREAD) begin
                        arb.bus_cmd <= MNONE;
                    end
                end
                S_RDATA: begin
                    arb.bus_cmd <= MNONE;
                    if (last) begin
                        arb.rdata1  <= arb.bus_rdata;
                        arb.rvalid1 <= 1'b1;
                    end else begin
                        arb.rdata0  <= arb.bus_rdata;
                        arb.rvalid0 <= 1'b1;
                    end
                end
                default: arb.bus_cmd <= MNONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM/LED/switch environment, a transaction-level
// timeline model of the arbiter, a per-cycle compare process and directed tests.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] sw;
    logic [15:0] led;
    logic [15:0] ram [256];
    logic [15:0] ram_dout;

    mem_arbiter_if bif ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Environment: synchronous RAM with one-cycle read latency, LED register, switch input.
    always @(posedge clk) begin
        ram_dout <= ram[bif.bus_addr[7:0]];
        if (bif.bus_cmd == MWRITE) begin
            if (!bif.bus_addr[8]) ram[bif.bus_addr[7:0]] <= bif.bus_wdata;
            else if (bif.bus_addr == 9'h100) led <= bif.bus_wdata;
        end
    end
    assign bif.bus_rdata = (bif.bus_cmd == MREAD && bif.bus_addr == 9'h140) ? sw : ram_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected timeline, indexed by cycle number.
    bit          exp_g0  [MAXC];
    bit          exp_g1  [MAXC];
    bit          exp_rv0 [MAXC];
    bit          exp_rv1 [MAXC];
    bit          exp_err [MAXC];
    bit          rst_at  [MAXC];
    logic [2:0]  exp_cmd [MAXC];
    logic [8:0]  exp_addr[MAXC];
    logic [15:0] exp_wd  [MAXC];
    logic [15:0] exp_rvd0[MAXC];
    logic [15:0] exp_rvd1[MAXC];
    logic [15:0] model_mem [256];
    bit          m_last;
    bit          m_err;
    int          m_idle_at;

    function automatic bit legal(input logic [2:0] c);
        return c == 3'b001 || c == 3'b010 || c == 3'b100;
    endfunction

    // Model: at each edge decide what the arbiter does with the inputs of the ending cycle.
    always @(posedge clk) begin
        logic [2:0]  c0, c1, cmd;
        logic [8:0]  a;
        logic [15:0] d, rd;
        bit r0, r1, w;
        c0 = bif.req_cmd0;
        c1 = bif.req_cmd1;
        if (reset) begin
            for (int k = cyc + 1; k < MAXC; k++) begin
                exp_g0[k] = 0; exp_g1[k] = 0; exp_rv0[k] = 0; exp_rv1[k] = 0;
                exp_cmd[k] = MNONE; exp_addr[k] = '0; exp_wd[k] = '0;
            end
            if (cyc + 1 < MAXC) begin
                rst_at[cyc + 1]  = 1;
                exp_err[cyc + 1] = 0;
            end
            m_last = 1; m_err = 0; m_idle_at = cyc + 1;
        end else if (cyc + 3 < MAXC) begin
            if (!legal(c0) || !legal(c1)) m_err = 1;
            exp_err[cyc + 1] = m_err;
            if (cyc >= m_idle_at) begin
                r0 = (c0 == 3'b010) || (c0 == 3'b100);
                r1 = (c1 == 3'b010) || (c1 == 3'b100);
                if (r0 || r1) begin
                    w      = (r0 && r1) ? !m_last : r1;
                    m_last = w;
                    cmd    = w ? c1 : c0;
                    a      = w ? bif.req_addr1 : bif.req_addr0;
                    d      = w ? bif.req_wdata1 : bif.req_wdata0;
                    if (w) exp_g1[cyc + 1] = 1; else exp_g0[cyc + 1] = 1;
                    exp_cmd[cyc + 1] = cmd; exp_addr[cyc + 1] = a; exp_wd[cyc + 1] = d;
                    if (cmd == 3'b100) begin
                        if (!a[8]) model_mem[a[7:0]] = d;
                        m_idle_at = cyc + 2;
                    end else begin
                        exp_cmd[cyc + 2] = 3'b010; exp_addr[cyc + 2] = a; exp_wd[cyc + 2] = d;
                        rd = a[8] ? sw : model_mem[a[7:0]];
                        if (w) begin exp_rv1[cyc + 3] = 1; exp_rvd1[cyc + 3] = rd; end
                        else   begin exp_rv0[cyc + 3] = 1; exp_rvd0[cyc + 3] = rd; end
                        m_idle_at = cyc + 3;
                    end
                end
            end
        end
        cyc++;
    end

    // Compare every cycle against the timeline; rdata is tracked as a held value.
    logic [15:0] m_rd0 = '0;
    logic [15:0] m_rd1 = '0;
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            if (rst_at[cyc]) begin m_rd0 = '0; m_rd1 = '0; end
            if (exp_rv0[cyc]) m_rd0 = exp_rvd0[cyc];
            if (exp_rv1[cyc]) m_rd1 = exp_rvd1[cyc];
            chk("m_grant0",  32'(bif.grant0),  32'(exp_g0[cyc]));
            chk("m_grant1",  32'(bif.grant1),  32'(exp_g1[cyc]));
            chk("m_rvalid0", 32'(bif.rvalid0), 32'(exp_rv0[cyc]));
            chk("m_rvalid1", 32'(bif.rvalid1), 32'(exp_rv1[cyc]));
            chk("m_bus_cmd", 32'(bif.bus_cmd), 32'(exp_cmd[cyc]));
            chk("m_cmd_err", 32'(bif.cmd_err), 32'(exp_err[cyc]));
            chk("m_rdata0",  32'(bif.rdata0),  32'(m_rd0));
            chk("m_rdata1",  32'(bif.rdata1),  32'(m_rd1));
            if (exp_cmd[cyc] != MNONE) chk("m_bus_addr", 32'(bif.bus_addr), 32'(exp_addr[cyc]));
            if (exp_cmd[cyc] == MWRITE) chk("m_bus_wdata", 32'(bif.bus_wdata), 32'(exp_wd[cyc]));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    int gq[$];
    int g0c, rv0c;

    initial begin
        for (int k = 0; k < MAXC; k++) exp_cmd[k] = MNONE;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            ram[i]       = {b, ~b};
            model_mem[i] = {b, ~b};
        end
        ram[5] = 16'h1234;
        model_mem[5] = 16'h1234;
        led = '0;
        sw  = 16'h003C;
        bif.req_cmd0 = MNONE; bif.req_addr0 = '0; bif.req_wdata0 = '0;
        bif.req_cmd1 = MNONE; bif.req_addr1 = '0; bif.req_wdata1 = '0;
        reset = 1'b1;

        // Reset for two cycles, then idle.
        step(); chk_en = 1'b1;
        step(); reset = 1'b0;
        chk("rst_bus_addr", 32'(bif.bus_addr), 32'h0);
        chk("rst_bus_wdata", 32'(bif.bus_wdata), 32'h0);
        repeat (5) begin
            step();
            chk("rst_bus_cmd", 32'(bif.bus_cmd), 32'h1);
            chk("rst_pulses", 32'({bif.grant0, bif.grant1, bif.rvalid0, bif.rvalid1}), 32'h0);
            chk("rst_cmd_err", 32'(bif.cmd_err), 32'h0);
        end

        // Port 0 writes the LED register.
        bif.req_cmd0 = MWRITE; bif.req_addr0 = 9'h100; bif.req_wdata0 = 16'h00A5;
        step();
        chk("wr_grant0", 32'(bif.grant0), 32'h1);
        chk("wr_cmd", 32'(bif.bus_cmd), 32'h4);
        chk("wr_addr", 32'(bif.bus_addr), 32'h100);
        chk("wr_wdata", 32'(bif.bus_wdata), 32'h00A5);
        bif.req_cmd0 = MNONE;
        step();
        chk("wr_cmd_once", 32'(bif.bus_cmd), 32'h1);
        chk("wr_led", 32'(led), 32'h00A5);

        // Port 1 reads preloaded RAM word 0x005.
        bif.req_cmd1 = MREAD; bif.req_addr1 = 9'h005;
        step();
        chk("rd_grant1", 32'(bif.grant1), 32'h1);
        bif.req_cmd1 = MNONE;
        step();
        chk("rd_early_rvalid", 32'(bif.rvalid1), 32'h0);
        step();
        chk("rd_rvalid1", 32'(bif.rvalid1), 32'h1);
        chk("rd_rdata1", 32'(bif.rdata1), 32'h1234);
        chk("rd_rdata0", 32'(bif.rdata0), 32'h0);
        step();
        chk("rd_rvalid1_pulse", 32'(bif.rvalid1), 32'h0);
        chk("rd_rdata1_held", 32'(bif.rdata1), 32'h1234);

        // Simultaneous write (port 0) and read of the same word (port 1): port 0 wins, read sees new data.
        bif.req_cmd0 = MWRITE; bif.req_addr0 = 9'h033; bif.req_wdata0 = 16'hBEEF;
        bif.req_cmd1 = MREAD;  bif.req_addr1 = 9'h033;
        step();
        chk("wr_rd_grant0", 32'(bif.grant0), 32'h1);
        bif.req_cmd0 = MNONE;
        step();
        step();
        chk("wr_rd_grant1", 32'(bif.grant1), 32'h1);
        bif.req_cmd1 = MNONE;
        step();
        step();
        chk("wr_rd_rdata1", 32'(bif.rdata1), 32'hBEEF);

        // Malformed command: no grant, sticky error until reset.
        bif.req_cmd0 = 3'b011;
        repeat (4) begin
            step();
            chk("bad_no_grant", 32'(bif.grant0), 32'h0);
            chk("bad_bus_cmd", 32'(bif.bus_cmd), 32'h1);
        end
        chk("bad_err_set", 32'(bif.cmd_err), 32'h1);
        bif.req_cmd0 = MNONE;
        repeat (3) step();
        chk("bad_err_sticky", 32'(bif.cmd_err), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("bad_err_cleared", 32'(bif.cmd_err), 32'h0);

        // Contention: both ports read continuously.
        bif.req_cmd0 = MREAD; bif.req_addr0 = 9'h010;
        bif.req_cmd1 = MREAD; bif.req_addr1 = 9'h020;
        g0c = -100; rv0c = -100;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bif.grant0) begin gq.push_back(0); if (g0c < 0) g0c = i; end
            if (bif.grant1) gq.push_back(1);
            if (bif.rvalid0 && rv0c < 0) rv0c = i;
        end
        bif.req_cmd0 = MNONE; bif.req_cmd1 = MNONE;
        if (gq.size() < 4) chk("cont_count", 32'(gq.size()), 32'd4);
        else for (int i = 0; i < 4; i++) chk("cont_order", 32'(gq[i]), 32'(i % 2));
        chk("cont_gap0", 32'(rv0c - g0c), 32'd2);
        repeat (4) step();
        chk("cont_rdata0", 32'(bif.rdata0), 32'h10EF);
        chk("cont_rdata1", 32'(bif.rdata1), 32'h20DF);

        // Reset while a switch read sits in S_RDATA.
        bif.req_cmd0 = MREAD; bif.req_addr0 = 9'h140;
        step();
        chk("rr_grant0", 32'(bif.grant0), 32'h1);
        bif.req_cmd0 = MNONE;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_no_rvalid", 32'(bif.rvalid0), 32'h0);
        chk("rr_rdata0", 32'(bif.rdata0), 32'h0);
        chk("rr_bus_cmd", 32'(bif.bus_cmd), 32'h1);

        // Normal switch read afterwards.
        bif.req_cmd0 = MREAD; bif.req_addr0 = 9'h140;
        step();
        bif.req_cmd0 = MNONE;
        step();
        step();
        chk("sw_rvalid0", 32'(bif.rvalid0), 32'h1);
        chk("sw_rdata0", 32'(bif.rdata0), 32'h003C);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
